// File: rtl/clock_pkg.sv
// Shared definitions for the clock_ctrl slice: FSM states, mode encodings,
// digit moduli and a helper that turns the BCD hour digits into a binary value.
`timescale 1ns/1ps

package clock_pkg;

    localparam int DEC_MOD  = 10;
    localparam int TENS_MOD = 6;
    localparam int HOURS_24 = 24;
    localparam int HOURS_12 = 12;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_HOUR = MODE_SET_HOUR,
        ST_SET_MIN  = MODE_SET_MIN
    } state_t;

    function automatic logic [4:0] hour_value(input logic [1:0] tens, input logic [3:0] ones);
        return 5'(tens) * 5'(DEC_MOD) + 5'(ones);
    endfunction

endpackage

// File: rtl/digit_counter.sv
// Single display digit: modulo-MOD counter with enable, synchronous clear to
// CLR_VAL and a carry-out that fires on the enabled wrap from MOD-1 to 0.
`timescale 1ns/1ps

module digit_counter #(
    parameter int               WIDTH   = 4,
    parameter int               MOD     = 10,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_q,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every digit samples the pre-edge carries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= (r_q == LAST) ? '0 : r_q + WIDTH'(1);
        end
    end

    assign o_q     = r_q;
    assign o_carry = i_en && (r_q == LAST);

endmodule

// File: rtl/clock_ctrl.sv
// HH:MM:SS BCD clock with RUN / SET_HOUR / SET_MIN modes and a set-mode blink strobe.
// Define CLOCK_CTRL_12H_EN for a 1..12 hour display that resets to 12:00:00.
`timescale 1ns/1ps

module clock_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [1:0] hour_tens,
    output logic [1:0] mode,
    output logic       blink
);

`ifdef CLOCK_CTRL_12H_EN
    localparam logic [4:0] HOUR_LAST      = 5'(HOURS_12);
    localparam int         HOUR_TENS_MOD  = HOURS_12 / DEC_MOD + 1;
    localparam logic [1:0] HOUR_TENS_INIT = 2'd1;
    localparam logic [3:0] HOUR_ONES_INIT = 4'd2;
    localparam logic [3:0] HOUR_ONES_WRAP = 4'd1;
`else
    localparam logic [4:0] HOUR_LAST      = 5'(HOURS_24 - 1);
    localparam int         HOUR_TENS_MOD  = (HOURS_24 - 1) / DEC_MOD + 1;
    localparam logic [1:0] HOUR_TENS_INIT = 2'd0;
    localparam logic [3:0] HOUR_ONES_INIT = 4'd0;
    localparam logic [3:0] HOUR_ONES_WRAP = 4'd0;
`endif

    localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);

    state_t     r_state;
    logic       r_armed;
    logic       r_mode_d;
    logic       r_inc_d;
    logic       r_blink;
    logic [3:0] r_blink_cnt;

    logic w_run, w_set_hour, w_set_min;
    logic w_mode_edge, w_inc_edge;
    logic w_so_carry, w_st_carry, w_mo_carry, w_mt_carry, w_ho_carry, w_ht_carry;
    logic w_sec_en, w_sec_clr, w_min_en, w_hour_step, w_hour_wrap;

    // r_armed stays low for the first edge after reset so a button held through reset is not seen as a press.
    assign w_mode_edge = r_armed && btn_mode && !r_mode_d;
    assign w_inc_edge  = r_armed && btn_inc  && !r_inc_d;

    assign w_run      = (r_state == ST_RUN);
    assign w_set_hour = (r_state == ST_SET_HOUR);
    assign w_set_min  = (r_state == ST_SET_MIN);

    assign w_sec_en    = w_run && tick_1hz;
    assign w_sec_clr   = w_set_min && w_mode_edge;
    assign w_min_en    = (w_run && w_st_carry) || (w_set_min && w_inc_edge);
    assign w_hour_step = (w_run && w_mt_carry) || (w_set_hour && w_inc_edge);
    // The tens carry is unreachable with legal digits; folding it in keeps a corrupted hour recoverable.
    assign w_hour_wrap = (w_hour_step && (hour_value(hour_tens, hour_ones) == HOUR_LAST)) || w_ht_carry;

    digit_counter #(.WIDTH(4), .MOD(DEC_MOD)) u_sec_ones (
        .clk(clk), .rst(rst), .i_en(w_sec_en), .i_clr(w_sec_clr),
        .o_q(sec_ones), .o_carry(w_so_carry)
    );

    digit_counter #(.WIDTH(3), .MOD(TENS_MOD)) u_sec_tens (
        .clk(clk), .rst(rst), .i_en(w_so_carry), .i_clr(w_sec_clr),
        .o_q(sec_tens), .o_carry(w_st_carry)
    );

    digit_counter #(.WIDTH(4), .MOD(DEC_MOD)) u_min_ones (
        .clk(clk), .rst(rst), .i_en(w_min_en), .i_clr(1'b0),
        .o_q(min_ones), .o_carry(w_mo_carry)
    );

    digit_counter #(.WIDTH(3), .MOD(TENS_MOD)) u_min_tens (
        .clk(clk), .rst(rst), .i_en(w_mo_carry), .i_clr(1'b0),
        .o_q(min_tens), .o_carry(w_mt_carry)
    );

    digit_counter #(.WIDTH(4), .MOD(DEC_MOD), .RST_VAL(HOUR_ONES_INIT), .CLR_VAL(HOUR_ONES_WRAP)) u_hour_ones (
        .clk(clk), .rst(rst), .i_en(w_hour_step), .i_clr(w_hour_wrap),
        .o_q(hour_ones), .o_carry(w_ho_carry)
    );

    digit_counter #(.WIDTH(2), .MOD(HOUR_TENS_MOD), .RST_VAL(HOUR_TENS_INIT)) u_hour_tens (
        .clk(clk), .rst(rst), .i_en(w_ho_carry), .i_clr(w_hour_wrap),
        .o_q(hour_tens), .o_carry(w_ht_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_armed     <= 1'b0;
            r_mode_d    <= 1'b0;
            r_inc_d     <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_armed  <= 1'b1;
            r_mode_d <= btn_mode;
            r_inc_d  <= btn_inc;
            if (w_mode_edge) begin
                case (r_state)
                    ST_RUN:      r_state <= ST_SET_HOUR;
                    ST_SET_HOUR: r_state <= ST_SET_MIN;
                    default:     r_state <= ST_RUN;
                endcase
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (w_run) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (tick_1hz) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink     <= !r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 4'd1;
                end
            end
        end
    end

    assign mode  = r_state;
    assign blink = r_blink;

endmodule
